// File: rtl/psc_pkg.sv
// Shared types and reset constants for the pattern scan controller.
package psc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_PATTERN = 'b10010;
  localparam int DEF_LEN     = 5;
  localparam int DEF_LIMIT   = 0;

endpackage

// File: rtl/pattern_matcher.sv
// Overlapping bit-serial pattern matcher: history shift register, saturating
// bits-seen counter and a length-masked compare on the next history value.
module pattern_matcher #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [PAT_MAX-1:0] hist_q, hist_next, mask;
  logic [LEN_W-1:0]   seen_q, seen_next, eff_len;

  // The compare looks at the history as it will be after this bit, so a
  // match is flagged on the same edge that shifts in its completing bit.
  always_comb begin
    hist_next = {hist_q[PAT_MAX-2:0], bit_in};
    seen_next = (seen_q >= LEN_W'(PAT_MAX)) ? seen_q : seen_q + LEN_W'(1);
    eff_len   = (len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : len;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end
    hit = shift_en && (eff_len != '0) && (seen_next >= eff_len) &&
          ((hist_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      seen_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_next;
      seen_q <= seen_next;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer: accepts words, shifts them MSB-first through the matcher and
// counts matches. Define PSC_ABORT_EN to add the abort input.
module pattern_scan_ctrl
  import psc_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               start,
`ifdef PSC_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_next;

  logic [WORD_W-1:0]  word_q;
  logic               last_q;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q, match_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   limit_q;

  logic abort_req, shift_en, load_word, clear, hit, limit_hit;

`ifdef PSC_ABORT_EN
  assign abort_req = abort && (state_q == LOAD || state_q == SHIFT);
`else
  assign abort_req = 1'b0;
`endif

  assign shift_en  = (state_q == SHIFT) && !abort_req;
  assign in_ready  = (state_q == LOAD) && !abort_req;
  assign load_word = in_ready && in_valid;
  assign clear     = (state_q == IDLE) && start;
  // The limit fires only on the edge where the count actually becomes the limit.
  assign limit_hit = hit && (limit_q != '0) && (count_q != CNT_MAX) &&
                     ((count_q + CNT_W'(1)) == limit_q);

  pattern_matcher #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W)) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (word_q[WORD_W-1]),
    .clear    (clear),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  if (in_valid) state_next = SHIFT;
      SHIFT: begin
        if (limit_hit)                              state_next = DONE;
        else if (bit_idx == IDX_W'(WORD_W - 1))     state_next = last_q ? DONE : LOAD;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_req) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      last_q     <= 1'b0;
      bit_idx    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
      pat_q      <= PAT_MAX'(DEF_PATTERN);
      len_q      <= LEN_W'(DEF_LEN);
      limit_q    <= CNT_W'(DEF_LIMIT);
    end else begin
      if (state_q == IDLE && cfg_we) begin
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        limit_q <= cfg_limit;
      end
      match_q <= hit;
      if (clear) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (hit) begin
        if (count_q == CNT_MAX) overflow_q <= 1'b1;
        else                    count_q    <= count_q + CNT_W'(1);
      end
      if (load_word) begin
        word_q  <= in_data;
        last_q  <= in_last;
        bit_idx <= '0;
      end else if (shift_en) begin
        word_q  <= word_q << 1;
        bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized self-checking bench for pattern_scan_ctrl against a bit-stream
// reference model of the overlapping matcher and scan rules.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_limit;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready, busy, done, match, overflow;
  logic [7:0] match_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] tb_words [0:63];
  int m_pat, m_len, m_limit, m_hist, m_seen, m_count, m_ovf;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_limit   (cfg_limit),
    .start       (start),
`ifdef PSC_ABORT_EN
    .abort       (abort),
`endif
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .match_count (match_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_defaults();
    m_pat = 'b10010; m_len = 5; m_limit = 0;
    m_count = 0; m_ovf = 0;
  endtask

  task automatic set_cfg(input int p, input int l, input int lim);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_pattern = 8'(p); cfg_len = 4'(l); cfg_limit = 8'(lim);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_pat = p; m_len = l; m_limit = lim;
  endtask

  // Runs one scan over tb_words[0..nwords-1] and checks every cycle.
  task automatic do_scan(input string name, input int nwords, input bit cfg_with_start,
                         input bit noise, input int np, input int nl, input int nlim);
    int eff, mask, b;
    bit stop, hit, lim, exp_done, exp_ready;
    logic [11:0] obs, exp_v;
    @(posedge clk); #1;
    start = 1'b1;
    if (cfg_with_start) begin
      cfg_we = 1'b1; cfg_pattern = 8'(np); cfg_len = 4'(nl); cfg_limit = 8'(nlim);
      m_pat = np; m_len = nl; m_limit = nlim;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    m_hist = 0; m_seen = 0; m_count = 0; m_ovf = 0; stop = 1'b0;
    eff  = (m_len > 8) ? 8 : m_len;
    mask = (1 << eff) - 1;
    obs = {match, done, in_ready, busy, match_count, overflow};
    exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s/start: got %h expected %h", name, obs, exp_v);
    end
    for (int w = 0; w < nwords && !stop; w++) begin
      in_valid = 1'b1; in_data = tb_words[w]; in_last = (w == nwords - 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
      obs = {match, done, in_ready, busy, match_count, overflow};
      exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 8'(m_count), m_ovf[0]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s/accept w=%0d: got %h expected %h", name, w, obs, exp_v);
      end
      for (int k = 0; k < 8; k++) begin
        if (noise && k < 7) begin
          cfg_we = 1'($urandom); cfg_pattern = 8'($urandom);
          cfg_len = 4'($urandom); cfg_limit = 8'($urandom);
          start = 1'($urandom);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        b = int'(tb_words[w][7-k]);
        m_hist = ((m_hist << 1) | b) & 255;
        m_seen = (m_seen >= 8) ? 8 : m_seen + 1;
        hit = (eff != 0) && (m_seen >= eff) && ((m_hist & mask) == (m_pat & mask));
        lim = 1'b0;
        if (hit) begin
          if (m_count == 255) m_ovf = 1;
          else begin
            m_count++;
            lim = (m_limit != 0) && (m_count == m_limit);
          end
        end
        exp_done  = lim || (k == 7 && w == nwords - 1);
        exp_ready = (k == 7) && !exp_done;
        obs = {match, done, in_ready, busy, match_count, overflow};
        exp_v = {hit, exp_done, exp_ready, 1'b1, 8'(m_count), m_ovf[0]};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL %s/bit w=%0d k=%0d: got %h expected %h", name, w, k, obs, exp_v);
        end
        if (exp_done) begin
          stop = 1'b1;
          break;
        end
      end
    end
    @(posedge clk); #1;
    obs = {match, done, in_ready, busy, match_count, overflow};
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 8'(m_count), m_ovf[0]};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s/idle: got %h expected %h", name, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_limit = '0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    model_defaults();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({match, done, in_ready, busy, match_count, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got %h expected 000",
               {match, done, in_ready, busy, match_count, overflow});
    end
    rst = 1'b0;
  endtask

  task automatic test_default_word();
    tb_words[0] = 8'b1001_0010;
    do_scan("default", 1, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL default_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_limit();
    set_cfg('b10010, 5, 1);
    tb_words[0] = 8'b1001_0010;
    do_scan("limit", 1, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL limit_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_cross_boundary();
    set_cfg('b10010, 5, 0);
    tb_words[0] = 8'b0000_0100;
    tb_words[1] = 8'b1000_0000;
    do_scan("cross", 2, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL cross_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_saturation();
    set_cfg(1, 1, 0);
    for (int i = 0; i < 32; i++) tb_words[i] = 8'hFF;
    do_scan("saturate", 32, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (match_count !== 8'd255 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturate_final: got count=%0d ovf=%b expected count=255 ovf=1",
               match_count, overflow);
    end
  endtask

  task automatic test_reset_mid_scan();
    set_cfg(8'hFF, 3, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({match, done, in_ready, busy, match_count, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 000",
               {match, done, in_ready, busy, match_count, overflow});
    end
    model_defaults();
    @(posedge clk); #1;
    rst = 1'b0;
    tb_words[0] = 8'b1001_0010;
    do_scan("after_reset", 1, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL after_reset_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_random();
    int n, p, l, lim;
    for (int s = 0; s < 10; s++) begin
      n   = $urandom_range(1, 4);
      p   = $urandom_range(0, 255);
      l   = $urandom_range(0, 10);
      lim = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      for (int i = 0; i < n; i++) tb_words[i] = 8'($urandom);
      if (s % 2 == 0) begin
        set_cfg(p, l, lim);
        do_scan("random", n, 1'b0, 1'b1, 0, 0, 0);
      end else begin
        do_scan("random_cfgstart", n, 1'b1, 1'b1, p, l, lim);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg('b101, 3, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) tb_words[i] = 8'($urandom);
      do_scan("back_to_back", 2, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

`ifdef PSC_ABORT_EN
  task automatic test_abort();
    set_cfg(1, 1, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({match, done, in_ready, busy, match_count, overflow} !== {4'b0000, 8'd3, 1'b0}) begin
        errors++;
        $display("FAIL abort c=%0d: got %h expected %h", c,
                 {match, done, in_ready, busy, match_count, overflow}, {4'b0000, 8'd3, 1'b0});
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_word();
    test_limit();
    test_cross_boundary();
    test_saturation();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
`ifdef PSC_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the bit-serial sequence-detector datapath. Accepts parallel words over a valid/ready handshake, shifts them MSB-first through a programmable overlapping pattern matcher, and counts matches. It ends a scan on a match limit or on the last word, and reports status to the host. It sits between the host register/stream interface and the detector datapath.

## Interface
- WORD_W, 8, input word width (≥2)
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 8, match counter width
- LEN_W, $clog2(PAT_MAX+1), width of length fields
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  config write strobe; ignored while busy
- cfg_pattern  in  PAT_MAX  pattern, right-aligned (bit 0 = newest bit)
- cfg_len  in  LEN_W  pattern length in bits
- cfg_limit  in  CNT_W  stop after this many matches; 0 = unlimited
- start  in  1  begin scan; ignored while busy
- in_valid  in  1  word available
- in_data  in  WORD_W  word, MSB shifted first
- in_last  in  1  final word of the scan; qualified by the handshake
- in_ready  out  1  controller accepts a word this cycle
- busy  out  1  high in LOAD, SHIFT, DONE
- done  out  1  one-cycle pulse at end of scan
- match  out  1  one-cycle pulse per detected pattern
- match_count  out  CNT_W  matches in current or last scan; saturating
- overflow  out  1  sticky; a match occurred while count was saturated

## Operation
- States:
  - IDLE: start → LOAD.
  - LOAD: in_ready=1. On in_valid: capture word and in_last, clear bit index, → SHIFT.
  - SHIFT: one bit per cycle, MSB first. After bit WORD_W-1: → DONE if the captured last flag is set, else → LOAD. Any cycle → DONE when the limit is reached.
  - DONE: done=1 → IDLE.
- start in IDLE clears history, the bits-seen counter, match_count and overflow.
- Match detection:
  - Each SHIFT edge shifts the bit into a PAT_MAX-bit history.
  - A match requires next-history[cfg_len-1:0] == cfg_pattern[cfg_len-1:0] and bits-seen (saturating at PAT_MAX) ≥ cfg_len.
  - Matches overlap; history is not cleared on a match. Matches span word boundaries.
- cfg_len=0: no matches ever. cfg_len>PAT_MAX: clamped to PAT_MAX.
- Limit:
  - With cfg_limit≠0, the edge at which match_count becomes cfg_limit moves to DONE.
  - The remaining bits of the word are discarded.
  - A pending last flag is irrelevant.
- match_count saturates at 2^CNT_W-1. A further match sets overflow, and match still pulses.
- The config registers (pattern, len, limit) are written only in IDLE. cfg_we together with start in IDLE: the new config is written, and the scan uses it.
- Reset values:
  - State IDLE.
  - in_ready, busy, done, match, overflow = 0; match_count = 0; history = 0.
  - pattern = 'b10010, len = 5, limit = 0.
- Reset mid-scan returns everything to the reset values. The in-flight word is lost.

## Timing
- start sampled at edge t → in_ready high from cycle t+1.
- Word accepted at edge a → bits shift at edges a+1 … a+WORD_W.
- match and the incremented match_count are visible in the cycle after the completing bit's shift edge.
- The DONE cycle coincides with the final match pulse when the scan ends on the limit.
- Throughput: WORD_W+1 cycles per word. in_ready is never high in SHIFT.
- done is high exactly one cycle. busy falls the cycle after done.
- match_count and overflow hold after DONE until the next start.

## Configuration
- PSC_ABORT_EN:
  - Defined: adds input port abort (1 bit). abort in LOAD or SHIFT → IDLE next edge, without passing through DONE. done is not pulsed, and match_count/overflow hold their values. abort has priority over the limit and the last flag in the same cycle.
  - Undefined: the port is absent, and scans end only via the limit, the last word or rst.

## Structure
- Package psc_pkg: state enum (IDLE, LOAD, SHIFT, DONE), default pattern/length/limit constants.
- Sub-module pattern_matcher: history shift register, bits-seen counter, length-masked compare; inputs shift_en, bit_in, clear, pattern, len; output hit (combinational on next-history).
- The top level holds the FSM, word register, bit index, match counter and config registers.

## Test plan
- Default config, word 8'b1001_0010 with last → match pulses after bits 4 and 7; match_count=2; done one cycle after the final shift.
- Same word, cfg_limit=1 → one match, done in the cycle after bit 4, bits 5–7 discarded, match_count=1.
- Words 8'b0000_0100 then 8'b1000_0000 (last) → one match after bit 1 of the second word (cross-boundary), match_count=1.
- cfg_pattern=1, cfg_len=1, 32 words 8'hFF, last on the 32nd → match_count=255, overflow=1 after the 256th match.
- rst asserted mid-SHIFT → all outputs 0 immediately. A subsequent start uses pattern 'b10010, len 5.
- PSC_ABORT_EN: abort in SHIFT after 3 bits → IDLE next cycle, no done pulse, match_count unchanged.
